// File: rtl/seq_mult_unsigned.sv
// Multi-cycle unsigned shift-add multiplier with a start/busy/done handshake.
// Optional macro SEQ_MULT_EARLY_TERM_EN stops early once no multiplier bits remain.
module seq_mult_unsigned #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [2*WIDTH-1:0] product_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] sum;

    // Accumulator value after this iteration's conditional add.
    always_comb begin
        sum = acc;
        if (mplier[0]) sum = acc + mcand;
    end

    // Handshake FSM and shift-add datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            product_out <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        mcand    <= {{WIDTH{1'b0}}, a_in};
                        mplier   <= b_in;
                        acc      <= '0;
                        cnt      <= '0;
                        busy_out <= 1'b1;
                        state    <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
                    if (cnt == LAST) begin
                        product_out <= sum;
                        done_out    <= 1'b1;
                        busy_out    <= 1'b0;
                        state       <= DONE;
                    end else if (mplier == '0) begin
                        product_out <= acc;
                        done_out    <= 1'b1;
                        busy_out    <= 1'b0;
                        state       <= DONE;
                    end
`else
                    if (cnt == LAST) begin
                        product_out <= sum;
                        done_out    <= 1'b1;
                        busy_out    <= 1'b0;
                        state       <= DONE;
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_unsigned.sv
// Self-checking bench for seq_mult_unsigned.
// Random and directed operands checked against an arithmetic reference.
module tb_seq_mult_unsigned;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_in = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           busy_out;
    logic           done_out;
    logic [2*W-1:0] product_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    seq_mult_unsigned #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_in(start_in),
        .a_in(a_in),
        .b_in(b_in),
        .busy_out(busy_out),
        .done_out(done_out),
        .product_out(product_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int hi;
        if (b == '0) return 1;
        hi = 0;
        for (int i = 0; i < W; i++) if (b[i]) hi = i;
        return (hi + 2 > W) ? W : hi + 2;
`else
        return W;
`endif
    endfunction

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[2*W-1:0];
    endfunction

    // Starts an operation from the current negedge and waits for done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cyc,
                         output logic [2*W-1:0] prod, output bit early_chg);
        logic [2*W-1:0] prev;
        int n;
        prev = product_out;
        early_chg = 0;
        busy_cyc = 0;
        a_in = a;
        b_in = b;
        start_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        n = 0;
        if (busy_out) busy_cyc++;
        if (product_out !== prev) early_chg = 1;
        while (n < W + 4) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_out) break;
            if (busy_out) busy_cyc++;
            if (product_out !== prev) early_chg = 1;
        end
        lat = done_out ? n : -1;
        prod = product_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || product_out !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b prod=%0d, required 0 0 0",
                     busy_out, done_out, product_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy_out, done_out);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [2*W-1:0] p;
        bit chg;
        @(negedge clk);
        do_op(8'd13, 8'd11, lat, bc, p, chg);
        checks++;
        if (p !== 16'd143) begin
            failures++;
            $display("FAIL basic_prod: got %0d, required 143", p);
        end
        checks++;
        if (lat != model_lat(8'd11)) begin
            failures++;
            $display("FAIL basic_latency: got %0d, required %0d", lat, model_lat(8'd11));
        end
        checks++;
        if (bc != model_lat(8'd11) || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: cycles %0d busy_at_done %b, required %0d 0",
                     bc, busy_out, model_lat(8'd11));
        end
        checks++;
        if (chg) begin
            failures++;
            $display("FAIL basic_early_change: product changed before done, required stable");
        end
        @(negedge clk);
        checks++;
        if (done_out !== 1'b0 || product_out !== 16'd143) begin
            failures++;
            $display("FAIL basic_pulse_hold: done=%b prod=%0d, required 0 143", done_out, product_out);
        end
    endtask

    task automatic test_max();
        int lat, bc;
        logic [2*W-1:0] p;
        bit chg;
        @(negedge clk);
        do_op(8'd255, 8'd255, lat, bc, p, chg);
        checks++;
        if (p !== 16'hFE01 || lat != model_lat(8'd255)) begin
            failures++;
            $display("FAIL max_operands: prod=%h lat=%0d, required fe01 %0d",
                     p, lat, model_lat(8'd255));
        end
    endtask

    task automatic test_zero();
        int lat, bc;
        logic [2*W-1:0] p;
        bit chg;
        logic [W-1:0] av [4];
        logic [W-1:0] bv [4];
        av = '{8'd0, 8'd77, 8'd5, 8'd9};
        bv = '{8'd200, 8'd0, 8'd1, 8'd64};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            do_op(av[i], bv[i], lat, bc, p, chg);
            checks++;
            if (p !== model_prod(av[i], bv[i]) || lat != model_lat(bv[i])) begin
                failures++;
                $display("FAIL zero_edge_%0d: prod=%0d lat=%0d, required %0d %0d", i, p, lat,
                         model_prod(av[i], bv[i]), model_lat(bv[i]));
            end
        end
    endtask

    task automatic test_ignore_start();
        int n, extra;
        @(negedge clk);
        a_in = 8'd6;
        b_in = 8'd7;
        start_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_in = 8'd9;
        b_in = 8'd9;
        start_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        n = 2;
        while (n < W + 4) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_out) break;
        end
        checks++;
        if (done_out !== 1'b1 || product_out !== 16'd42 || n != model_lat(8'd7)) begin
            failures++;
            $display("FAIL ignore_start: done=%b prod=%0d lat=%0d, required 1 42 %0d",
                     done_out, product_out, n, model_lat(8'd7));
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_out || busy_out) extra++;
        end
        checks++;
        if (extra != 0 || product_out !== 16'd42) begin
            failures++;
            $display("FAIL ignore_second: extra_activity=%0d prod=%0d, required 0 42",
                     extra, product_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, t1, t2;
        logic [2*W-1:0] p;
        bit chg;
        @(negedge clk);
        do_op(8'd5, 8'd5, lat, bc, p, chg);
        t1 = cyc;
        checks++;
        if (p !== 16'd25) begin
            failures++;
            $display("FAIL b2b_first: prod=%0d, required 25", p);
        end
        do_op(8'd3, 8'd4, lat, bc, p, chg);
        t2 = cyc;
        checks++;
        if (p !== 16'd12 || chg) begin
            failures++;
            $display("FAIL b2b_second: prod=%0d early_change=%0d, required 12 0", p, chg);
        end
        checks++;
        if (t2 - t1 != model_lat(8'd4) + 1) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d, required %0d", t2 - t1, model_lat(8'd4) + 1);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, extra, rep;
        logic [2*W-1:0] p;
        bit chg;
        rep = (model_lat(8'd3) > 4) ? 4 : 1;
        @(negedge clk);
        a_in = 8'd100;
        b_in = 8'd3;
        start_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
        repeat (rep) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || product_out !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b prod=%0d, required 0 0 0",
                     busy_out, done_out, product_out);
        end
        extra = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done_out || busy_out) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL reset_no_done: activity=%0d, required 0", extra);
        end
        do_op(8'd10, 8'd10, lat, bc, p, chg);
        checks++;
        if (p !== 16'd100 || lat != model_lat(8'd10)) begin
            failures++;
            $display("FAIL reset_recover: prod=%0d lat=%0d, required 100 %0d",
                     p, lat, model_lat(8'd10));
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [2*W-1:0] p;
        bit chg;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 5 == 0) b = W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            do_op(a, b, lat, bc, p, chg);
            checks++;
            if (p !== model_prod(a, b) || lat != model_lat(b) || bc != model_lat(b)) begin
                failures++;
                $display("FAIL random_%0d: %0d*%0d prod=%0d lat=%0d busy=%0d, required %0d %0d %0d",
                         i, a, b, p, lat, bc, model_prod(a, b), model_lat(b), model_lat(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
